lcd_char_buffer: RTL
====================

Name: lcd_char_buffer

Overview:
32-entry character buffer that sits directly upstream of the LCD state machine. The host writes characters and simple commands through a valid/ready port. The LCD state machine reads bytes through its 5-bit addrToRead / 8-bit data path. The block also drives the LCD on-request line and a frame-dirty flag so the LCD side knows when to refresh.

Parameters:
DEPTH, 32, number of character cells (must equal 2^ADDR_W)
ADDR_W, 5, cell address width
FILL_CHAR, 8'h20, byte written by clear operations (ASCII space)

Ports:
clk  in  1  system clock, rising edge
resetN  in  1  asynchronous active-low reset
wrValid  in  1  host write request
wrReady  out  1  buffer can accept a write this cycle
wrData  in  8  character or command byte
wrIsCmd  in  1  1 = wrData is a command, 0 = character
addrToRead  in  ADDR_W  read address from the LCD state machine
dataOut  out  8  registered read data (feeds the state machine's dataIn)
lcdOnOut  out  1  display-on request (feeds the state machine's lcdOnIn)
frameDirty  out  1  buffer changed since the last acknowledged refresh
frameAck  in  1  one-cycle pulse: LCD side finished a full refresh
cursor  out  ADDR_W  current write position
cmdError  out  1  sticky, set on an unknown command

Behaviour:
- Reset (resetN low, asynchronous):
  - state = INIT_CLEAR, cursor = 0, clear index = 0.
  - wrReady = 0, lcdOnOut = 0, frameDirty = 0, cmdError = 0, dataOut = FILL_CHAR.
  - Memory is not reset directly; INIT_CLEAR fills it.
- States:
  - INIT_CLEAR / CLEAR: write FILL_CHAR to mem[clear index] and increment the index, one cell per cycle. After cell DEPTH-1 is written, go to IDLE and set the index to 0. A clear therefore takes exactly DEPTH cycles. wrReady = 0 throughout.
  - IDLE: wrReady = 1.
- Handshake: a transfer occurs on a rising edge with wrValid && wrReady. wrData and wrIsCmd must be stable while wrValid is high. wrValid may stay high across multiple cycles, and each ready cycle is a separate transfer.
- Character transfer (wrIsCmd = 0): mem[cursor] = wrData, then cursor = cursor + 1 mod DEPTH (31 wraps to 0).
- Command transfer (wrIsCmd = 1):
  - 8'h01 clear: go to CLEAR, cursor = 0.
  - 8'h02 home: cursor = 0.
  - 8'h0C display on: lcdOnOut = 1.
  - 8'h08 display off: lcdOnOut = 0.
  - 8'b100a_aaaa set cursor: cursor = wrData[4:0].
  - Any other value: ignored, cmdError = 1 (stays set until reset).
- Read port: dataOut <= mem[addrToRead] every rising edge (1-cycle latency).
  - Same-address read and write on the same edge returns the old data (read-before-write).
  - Reads during CLEAR return the old or fill data cell by cell, whichever is current.
- frameDirty:
  - Set on the edge that completes a character write, completes a clear (last cell), or changes lcdOnOut.
  - Cleared when frameAck = 1 and no set event occurs on the same edge. If both happen on the same edge, set wins.
  - After the reset INIT_CLEAR completes, frameDirty = 1.
- Edge cases:
  - Clear command while already in CLEAR: impossible, since wrReady = 0.
  - Set-cursor outside range: impossible, since it is a 5-bit field.
  - Display on when already on: no change, frameDirty not set.
  - resetN asserted mid-clear or mid-transfer: immediately return to the reset values above and restart INIT_CLEAR after release.

Test Plan:
1. Release reset, wait 32 cycles → wrReady rises on cycle 32, frameDirty = 1; reading addr 0..31 returns 8'h20 each, 1 cycle after the address.
2. Write chars 'A'(8'h41), 'B'(8'h42) back to back with wrValid held high → mem[0] = 8'h41, mem[1] = 8'h42, cursor = 2; addrToRead = 1 gives dataOut = 8'h42 on the next edge.
3. Set cursor with cmd 8'h9F, then write 8'h5A, then 8'h5B → mem[31] = 8'h5A, mem[0] = 8'h5B, cursor = 1 (wrap).
4. Cmd 8'h0C → lcdOnOut = 1, frameDirty = 1. Pulse frameAck → frameDirty = 0. Pulse frameAck on the same edge as a char write → frameDirty stays 1.
5. Cmd 8'h01 → wrReady = 0 for exactly 32 cycles, all cells read 8'h20, cursor = 0. Cmd 8'h33 → cmdError = 1, with no change to memory, cursor, or lcdOnOut.
6. Assert resetN low 5 cycles into a clear → outputs return to reset values asynchronously, and INIT_CLEAR reruns a full 32 cycles after release.

Source files
------------

// File: rtl/lcd_char_buffer.sv
// Character buffer feeding the LCD state machine: host valid/ready write port with
// character/command decode, registered read port, display-on request and frame-dirty tracking.
module lcd_char_buffer #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              wrValid,
    output logic              wrReady,
    input  logic [7:0]        wrData,
    input  logic              wrIsCmd,
    input  logic [ADDR_W-1:0] addrToRead,
    output logic [7:0]        dataOut,
    output logic              lcdOnOut,
    output logic              frameDirty,
    input  logic              frameAck,
    output logic [ADDR_W-1:0] cursor,
    output logic              cmdError
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ON    = 8'h0C;
    localparam logic [7:0] CMD_OFF   = 8'h08;

    typedef enum logic [1:0] {
        S_INIT_CLEAR = 2'd0,
        S_CLEAR      = 2'd1,
        S_IDLE       = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cursor;
    logic [ADDR_W-1:0]   r_clr_idx;
    logic                r_wr_ready;
    logic                r_lcd_on;
    logic                r_dirty;
    logic                r_cmd_err;
    logic [7:0]          r_data_out;
    logic [7:0]          r_mem [DEPTH];

    logic                w_xfer;
    logic                w_char_wr;
    logic                w_cmd;
    logic                w_clearing;
    logic                w_clr_last;
    logic                w_cmd_clear;
    logic                w_cmd_home;
    logic                w_cmd_on;
    logic                w_cmd_off;
    logic                w_cmd_setcur;
    logic                w_cmd_bad;
    logic                w_lcd_change;
    logic                w_dirty_set;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [7:0]          w_mem_wdata;

    // Transfer qualification, command decode and memory write-port selection
    always_comb begin
        w_xfer       = wrValid && r_wr_ready;
        w_char_wr    = w_xfer && !wrIsCmd;
        w_cmd        = w_xfer && wrIsCmd;
        w_clearing   = (r_state != S_IDLE);
        w_clr_last   = w_clearing && (r_clr_idx == LAST_IDX);
        w_cmd_clear  = 1'b0;
        w_cmd_home   = 1'b0;
        w_cmd_on     = 1'b0;
        w_cmd_off    = 1'b0;
        w_cmd_setcur = 1'b0;
        w_cmd_bad    = 1'b0;
        if (w_cmd) begin
            casez (wrData)
                CMD_CLEAR:    w_cmd_clear  = 1'b1;
                CMD_HOME:     w_cmd_home   = 1'b1;
                CMD_ON:       w_cmd_on     = 1'b1;
                CMD_OFF:      w_cmd_off    = 1'b1;
                8'b100?_????: w_cmd_setcur = 1'b1;
                default:      w_cmd_bad    = 1'b1;
            endcase
        end
        w_lcd_change = (w_cmd_on && !r_lcd_on) || (w_cmd_off && r_lcd_on);
        w_dirty_set  = w_char_wr || w_clr_last || w_lcd_change;

        w_mem_we    = 1'b0;
        w_mem_addr  = r_cursor;
        w_mem_wdata = wrData;
        if (w_clearing) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_idx;
            w_mem_wdata = FILL_CHAR;
        end else if (w_char_wr) begin
            w_mem_we = 1'b1;
        end
    end

    // Control state: clear sequencing, cursor, display-on and error tracking
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_INIT_CLEAR;
            r_cursor   <= '0;
            r_clr_idx  <= '0;
            r_wr_ready <= 1'b0;
            r_lcd_on   <= 1'b0;
            r_dirty    <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            case (r_state)
                S_INIT_CLEAR, S_CLEAR: begin
                    if (w_clr_last) begin
                        r_state    <= S_IDLE;
                        r_clr_idx  <= '0;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + ADDR_W'(1);
                    end
                end
                S_IDLE: begin
                    if (w_char_wr) begin
                        r_cursor <= r_cursor + ADDR_W'(1);
                    end
                    if (w_cmd_clear) begin
                        r_state    <= S_CLEAR;
                        r_wr_ready <= 1'b0;
                        r_cursor   <= '0;
                    end
                    if (w_cmd_home) begin
                        r_cursor <= '0;
                    end
                    if (w_cmd_setcur) begin
                        r_cursor <= ADDR_W'(wrData[4:0]);
                    end
                    if (w_cmd_on) begin
                        r_lcd_on <= 1'b1;
                    end
                    if (w_cmd_off) begin
                        r_lcd_on <= 1'b0;
                    end
                    if (w_cmd_bad) begin
                        r_cmd_err <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_INIT_CLEAR;
                    r_clr_idx  <= '0;
                    r_wr_ready <= 1'b0;
                end
            endcase

            // A set event on the same edge as an acknowledge keeps the frame dirty
            if (w_dirty_set) begin
                r_dirty <= 1'b1;
            end else if (frameAck) begin
                r_dirty <= 1'b0;
            end
        end
    end

    // Cell storage; not reset, the init clear fills it
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Registered read port, returns pre-write contents on a same-edge collision
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_data_out <= FILL_CHAR;
        end else begin
            r_data_out <= r_mem[addrToRead];
        end
    end

    assign wrReady    = r_wr_ready;
    assign dataOut    = r_data_out;
    assign lcdOnOut   = r_lcd_on;
    assign frameDirty = r_dirty;
    assign cursor     = r_cursor;
    assign cmdError   = r_cmd_err;

endmodule
